// File: rtl/forwarding_regfile_if.sv
// Register file bus: read ports, forwarding sources, writeback,
// reservations and fetch PC update. master = pipeline, slave = regfile.
interface forwarding_regfile_if #(
  parameter int NREAD = 3,
  parameter int NFWD  = 2
);
  logic [NREAD-1:0][4:0]  rd_index;
  logic [NREAD-1:0][31:0] rd_value;
  logic                   rd_hold;

  logic [NFWD-1:0]        fb_valid;
  logic [NFWD-1:0]        fb_has_upper;
  logic [NFWD-1:0][4:0]   fb_index;
  logic [NFWD-1:0][31:0]  fb_value;
  logic [NFWD-1:0][31:0]  fb_upper_value;

  logic                   wr_valid;
  logic                   wr_has_upper;
  logic [4:0]             wr_index;
  logic [31:0]            wr_value;
  logic [31:0]            wr_upper_value;

  logic                   rsv_valid;
  logic                   rsv_has_upper;
  logic [4:0]             rsv_index;

  logic                   pc_load;
  logic [31:0]            pc_next;
  logic [31:0]            pc_value;
  logic [31:0]            flags_value;

  modport master (
    output rd_index,
    input  rd_value, rd_hold,
    output fb_valid, fb_has_upper, fb_index,
    output fb_value, fb_upper_value,
    output wr_valid, wr_has_upper, wr_index,
    output wr_value, wr_upper_value,
    output rsv_valid, rsv_has_upper, rsv_index,
    output pc_load, pc_next,
    input  pc_value, flags_value
  );

  modport slave (
    input  rd_index,
    output rd_value, rd_hold,
    input  fb_valid, fb_has_upper, fb_index,
    input  fb_value, fb_upper_value,
    input  wr_valid, wr_has_upper, wr_index,
    input  wr_value, wr_upper_value,
    input  rsv_valid, rsv_has_upper, rsv_index,
    input  pc_load, pc_next,
    output pc_value, flags_value
  );
endinterface

// File: rtl/forwarding_regfile.sv
// Register file with operand forwarding, pending-write scoreboard and
// PC/Flags registers. Ports: clock_i, reset_n_i (sync, active low), bus (slave).
module forwarding_regfile #(
  parameter int NR    = 32,
  parameter int NREAD = 3,
  parameter int NFWD  = 2
) (
  input  logic clock_i,
  input  logic reset_n_i,
  forwarding_regfile_if.slave bus
);
  localparam int         PC  = NR - 2;
  localparam int         FL  = NR - 1;
  localparam logic [5:0] NR6 = 6'(NR);

  logic [31:0]   regs_q [NR];
  logic [31:0]   regs_d [NR];
  logic [NR-1:0] pend_q, pend_d;
  logic [NR-1:0] wlo, whi, slo, shi;

  function automatic logic hit_lo(
    input logic v, input logic [4:0] si, input logic [4:0] ri);
    return v && (ri != 5'd0) && (ri == si);
  endfunction

  function automatic logic hit_hi(
    input logic v, input logic up,
    input logic [4:0] si, input logic [4:0] ri);
    return v && up && (ri != 5'd0) &&
           (6'(ri) == 6'(si) + 6'd1);
  endfunction

  // Per-register decode of write and reservation targets.
  // An upper half at index NR is never matched, so it is dropped.
  always_comb begin
    wlo = '0;
    whi = '0;
    slo = '0;
    shi = '0;
    for (int r = 1; r < NR; r++) begin
      wlo[r] = bus.wr_valid &&
               (6'(bus.wr_index) == 6'(r));
      whi[r] = bus.wr_valid && bus.wr_has_upper &&
               (6'(bus.wr_index) + 6'd1 == 6'(r));
      slo[r] = bus.rsv_valid &&
               (6'(bus.rsv_index) == 6'(r));
      shi[r] = bus.rsv_valid && bus.rsv_has_upper &&
               (6'(bus.rsv_index) + 6'd1 == 6'(r));
    end
  end

  always_comb begin
    pend_d = pend_q;
    for (int r = 0; r < NR; r++) regs_d[r] = regs_q[r];
    // Writeback to PC (either half) beats the fetch update.
    if (bus.pc_load && !wlo[PC] && !whi[PC])
      regs_d[PC] = bus.pc_next;
    for (int r = 1; r < NR; r++) begin
      if (wlo[r]) regs_d[r] = bus.wr_value;
      if (whi[r]) regs_d[r] = bus.wr_upper_value;
      if (wlo[r] || whi[r]) pend_d[r] = 1'b0;
      // Reservation is younger than the writeback it races.
      if (slo[r] || shi[r]) pend_d[r] = 1'b1;
    end
    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      for (int r = 0; r < NR; r++) regs_q[r] <= '0;
      pend_q <= '0;
    end else begin
      for (int r = 0; r < NR; r++) regs_q[r] <= regs_d[r];
      pend_q <= pend_d;
    end
  end

  // Returns {supplied_by_source, value}. Sources are applied oldest
  // first so the youngest match overwrites.
  function automatic logic [32:0] lookup(input logic [4:0] ri);
    logic [32:0] res;
    logic        inr;
    inr = 6'(ri) < NR6;
    res = {1'b0, inr ? regs_q[ri] : 32'h0};
    if (hit_lo(bus.wr_valid, bus.wr_index, ri))
      res = {1'b1, bus.wr_value};
    else if (hit_hi(bus.wr_valid, bus.wr_has_upper,
                    bus.wr_index, ri))
      res = {1'b1, bus.wr_upper_value};
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (hit_lo(bus.fb_valid[k], bus.fb_index[k], ri))
        res = {1'b1, bus.fb_value[k]};
      else if (hit_hi(bus.fb_valid[k], bus.fb_has_upper[k],
                      bus.fb_index[k], ri))
        res = {1'b1, bus.fb_upper_value[k]};
    end
    if (!inr) res = '0;
    return res;
  endfunction

  always_comb begin
    logic [32:0] lk;
    logic [4:0]  ri;
    bus.rd_hold = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      ri = bus.rd_index[p];
      lk = lookup(ri);
      bus.rd_value[p] = lk[31:0];
      if ((6'(ri) < NR6) && pend_q[ri] && !lk[32])
        bus.rd_hold = 1'b1;
    end
  end

  assign bus.pc_value    = regs_q[PC];
  assign bus.flags_value = regs_q[FL];
endmodule

// File: tb/tb_forwarding_regfile.sv
// Scoreboard bench for forwarding_regfile: expectations are queued as
// stimulus is driven and compared at the following falling edge.
module tb_forwarding_regfile;
  localparam int NR    = 32;
  localparam int NREAD = 3;
  localparam int NFWD  = 2;
  localparam int K_RD = 0, K_HOLD = 1, K_PC = 2, K_FL = 3;

  typedef struct {
    string       tag;
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  exp_t sb[$];

  forwarding_regfile_if #(.NREAD(NREAD), .NFWD(NFWD)) bus ();

  forwarding_regfile #(.NR(NR), .NREAD(NREAD), .NFWD(NFWD)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] observe(input int kind, input int port);
    case (kind)
      K_RD:    return bus.rd_value[port];
      K_HOLD:  return {31'b0, bus.rd_hold};
      K_PC:    return bus.pc_value;
      default: return bus.flags_value;
    endcase
  endfunction

  task automatic ev(input string tag, input int kind,
                    input int port, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.port = port; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic idle();
    bus.rd_index       = '0;
    bus.fb_valid       = '0;
    bus.fb_has_upper   = '0;
    bus.fb_index       = '0;
    bus.fb_value       = '0;
    bus.fb_upper_value = '0;
    bus.wr_valid       = 1'b0;
    bus.wr_has_upper   = 1'b0;
    bus.wr_index       = '0;
    bus.wr_value       = '0;
    bus.wr_upper_value = '0;
    bus.rsv_valid      = 1'b0;
    bus.rsv_has_upper  = 1'b0;
    bus.rsv_index      = '0;
    bus.pc_load        = 1'b0;
    bus.pc_next        = '0;
  endtask

  // Start a new cycle: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic sample();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.kind, e.port), e.exp);
    end
  endtask

  task automatic wr(input logic [4:0] i, input logic [31:0] v);
    bus.wr_valid = 1'b1;
    bus.wr_index = i;
    bus.wr_value = v;
  endtask

  task automatic wr2(input logic [4:0] i, input logic [31:0] v,
                     input logic [31:0] u);
    wr(i, v);
    bus.wr_has_upper   = 1'b1;
    bus.wr_upper_value = u;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    idle();
    step();
    step();
    bus.rd_index[0] = 5'd5;
    bus.rd_index[1] = 5'd31;
    bus.rd_index[2] = 5'd30;
    ev("rst_r5", K_RD, 0, 32'h0);
    ev("rst_r31", K_RD, 1, 32'h0);
    ev("rst_r30", K_RD, 2, 32'h0);
    ev("rst_hold", K_HOLD, 0, 32'h0);
    ev("rst_pc", K_PC, 0, 32'h0);
    ev("rst_flags", K_FL, 0, 32'h0);
    sample();
    rst_n = 1'b1;

    // write-through then array
    step(); wr(5'd5, 32'h1234); bus.rd_index[0] = 5'd5;
    ev("wt_r5", K_RD, 0, 32'h1234); sample();
    step(); bus.rd_index[0] = 5'd5;
    ev("arr_r5", K_RD, 0, 32'h1234); sample();

    // forwarding priority
    step(); wr(5'd7, 32'hC); bus.rd_index[1] = 5'd7;
    bus.fb_valid = 2'b11; bus.fb_index[0] = 5'd7; bus.fb_index[1] = 5'd7;
    bus.fb_value[0] = 32'hA; bus.fb_value[1] = 32'hB;
    ev("prio_fb0", K_RD, 1, 32'hA); sample();
    step(); wr(5'd7, 32'hC); bus.rd_index[1] = 5'd7;
    bus.fb_valid = 2'b10; bus.fb_index[1] = 5'd7; bus.fb_value[1] = 32'hB;
    ev("prio_fb1", K_RD, 1, 32'hB); sample();
    step(); wr(5'd7, 32'hC); bus.rd_index[1] = 5'd7;
    ev("prio_wr", K_RD, 1, 32'hC); sample();
    step(); bus.rd_index[1] = 5'd7;
    ev("prio_arr", K_RD, 1, 32'hC); sample();

    // paired writes, top register has no wrap
    step(); wr2(5'd31, 32'hDEAD, 32'hFF);
    sample();
    step(); bus.rd_index[0] = 5'd31; bus.rd_index[1] = 5'd0;
    ev("pair31_lo", K_RD, 0, 32'hDEAD);
    ev("pair31_r0", K_RD, 1, 32'h0);
    ev("pair31_flags", K_FL, 0, 32'hDEAD); sample();
    step(); wr2(5'd8, 32'h88, 32'h99); bus.rd_index[0] = 5'd9;
    ev("pair8_wt_hi", K_RD, 0, 32'h99); sample();
    step(); bus.rd_index[0] = 5'd8; bus.rd_index[1] = 5'd9;
    ev("pair8_r8", K_RD, 0, 32'h88);
    ev("pair8_r9", K_RD, 1, 32'h99); sample();

    // reservation and hold
    step(); bus.rsv_valid = 1'b1; bus.rsv_index = 5'd3;
    bus.rd_index[0] = 5'd3;
    ev("rsv_same_cyc", K_HOLD, 0, 32'h0); sample();
    step(); bus.rd_index[0] = 5'd3;
    ev("rsv_hold", K_HOLD, 0, 32'h1); sample();
    step(); bus.rd_index[0] = 5'd3;
    bus.fb_valid[1] = 1'b1; bus.fb_index[1] = 5'd3;
    bus.fb_value[1] = 32'h33;
    ev("rsv_fb1_hold", K_HOLD, 0, 32'h0);
    ev("rsv_fb1_val", K_RD, 0, 32'h33); sample();
    step(); wr(5'd3, 32'h44); bus.rd_index[0] = 5'd3;
    ev("rsv_wr_hold", K_HOLD, 0, 32'h0); sample();
    step(); bus.rd_index[0] = 5'd3;
    ev("rsv_clr_hold", K_HOLD, 0, 32'h0);
    ev("rsv_clr_val", K_RD, 0, 32'h44); sample();

    // paired reservation, upper-half forwarding
    step(); bus.rsv_valid = 1'b1; bus.rsv_has_upper = 1'b1;
    bus.rsv_index = 5'd10;
    sample();
    step(); bus.rd_index[0] = 5'd11;
    ev("rsv2_hold", K_HOLD, 0, 32'h1); sample();
    step(); bus.rd_index[0] = 5'd11; bus.rd_index[1] = 5'd10;
    bus.fb_valid[0] = 1'b1; bus.fb_has_upper[0] = 1'b1;
    bus.fb_index[0] = 5'd10;
    bus.fb_value[0] = 32'h70; bus.fb_upper_value[0] = 32'h77;
    ev("rsv2_fb_hi", K_RD, 0, 32'h77);
    ev("rsv2_fb_lo", K_RD, 1, 32'h70);
    ev("rsv2_fb_hold", K_HOLD, 0, 32'h0); sample();
    step(); wr2(5'd10, 32'hA0, 32'hB0);
    sample();
    step(); bus.rd_index[0] = 5'd11; bus.rd_index[1] = 5'd10;
    ev("rsv2_clr_hold", K_HOLD, 0, 32'h0);
    ev("rsv2_r11", K_RD, 0, 32'hB0);
    ev("rsv2_r10", K_RD, 1, 32'hA0); sample();

    // set beats clear on the same edge
    step(); wr(5'd4, 32'h4); bus.rsv_valid = 1'b1; bus.rsv_index = 5'd4;
    sample();
    step(); bus.rd_index[0] = 5'd4;
    ev("setclr_hold", K_HOLD, 0, 32'h1);
    ev("setclr_val", K_RD, 0, 32'h4); sample();
    step(); wr(5'd4, 32'h40);
    sample();
    step(); bus.rd_index[0] = 5'd4;
    ev("setclr_done", K_HOLD, 0, 32'h0); sample();

    // PC arbitration
    step(); wr(5'd30, 32'h200); bus.pc_load = 1'b1; bus.pc_next = 32'h100;
    ev("pc_no_fwd", K_PC, 0, 32'h0); sample();
    step(); bus.rd_index[0] = 5'd30;
    bus.pc_load = 1'b1; bus.pc_next = 32'h300;
    ev("pc_wr_wins", K_PC, 0, 32'h200);
    ev("pc_rd", K_RD, 0, 32'h200); sample();
    step(); wr2(5'd29, 32'h29, 32'h400);
    bus.pc_load = 1'b1; bus.pc_next = 32'h500;
    ev("pc_load", K_PC, 0, 32'h300); sample();
    step(); bus.rd_index[0] = 5'd29;
    ev("pc_upper_wins", K_PC, 0, 32'h400);
    ev("pc_r29", K_RD, 0, 32'h29); sample();

    // register 0
    step(); wr(5'd0, 32'h5); bus.rsv_valid = 1'b1; bus.rsv_index = 5'd0;
    bus.fb_valid[0] = 1'b1; bus.fb_index[0] = 5'd0; bus.fb_value[0] = 32'h9;
    ev("r0_fwd", K_RD, 0, 32'h0); sample();
    step();
    ev("r0_read", K_RD, 0, 32'h0);
    ev("r0_hold", K_HOLD, 0, 32'h0); sample();

    // reset mid-operation
    step(); bus.rsv_valid = 1'b1; bus.rsv_index = 5'd12;
    sample();
    step(); rst_n = 1'b0;
    wr(5'd5, 32'h999); bus.rsv_valid = 1'b1; bus.rsv_index = 5'd6;
    bus.pc_load = 1'b1; bus.pc_next = 32'h700; bus.rd_index[0] = 5'd12;
    ev("prerst_hold", K_HOLD, 0, 32'h1); sample();
    step(); rst_n = 1'b1;
    bus.rd_index[0] = 5'd5; bus.rd_index[1] = 5'd6; bus.rd_index[2] = 5'd12;
    ev("mrst_r5", K_RD, 0, 32'h0);
    ev("mrst_r6", K_RD, 1, 32'h0);
    ev("mrst_r12", K_RD, 2, 32'h0);
    ev("mrst_hold", K_HOLD, 0, 32'h0);
    ev("mrst_pc", K_PC, 0, 32'h0);
    ev("mrst_flags", K_FL, 0, 32'h0); sample();
    step(); wr(5'd5, 32'h55); bus.rsv_valid = 1'b1; bus.rsv_index = 5'd6;
    bus.pc_load = 1'b1; bus.pc_next = 32'h800;
    sample();
    step(); bus.rd_index[0] = 5'd5; bus.rd_index[1] = 5'd6;
    ev("post_r5", K_RD, 0, 32'h55);
    ev("post_hold", K_HOLD, 0, 32'h1);
    ev("post_pc", K_PC, 0, 32'h800); sample();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
